// File: rtl/otg_hpi_pkg.sv
// Shared definitions for the CY7C67200 Host Port Interface access controller:
// FSM state encoding, HPI register addresses and counter width.
package otg_hpi_pkg;

   localparam int CNT_W  = 4;
   localparam int DATA_W = 16;

   // HPI register selects carried on the two address pins
   localparam logic [1:0] HPI_DATA    = 2'd0;
   localparam logic [1:0] HPI_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_ADDRESS = 2'd2;
   localparam logic [1:0] HPI_STATUS  = 2'd3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      HOLD    = 3'd3,
      RECOVER = 3'd4
   } state_t;

endpackage

// File: rtl/otg_hpi_access_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous OTG interrupt line.
module otg_hpi_access_ctrl_sync2 (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Double-register the async input; both flops clear on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/otg_hpi_access_ctrl.sv
// Avalon-MM slave to CY7C67200 HPI access sequencer. Each accepted request runs
// SETUP -> STROBE -> HOLD -> RECOVER with programmable cycle counts; all pins
// are driven from registers computed off the next state.
// Optional build macro OTG_HPI_INT_SYNC_EN adds otg_int/irq with a 2-flop
// synchronizer between them.
module otg_hpi_access_ctrl
   import otg_hpi_pkg::*;
#(
   parameter int unsigned SETUP_CYC    = 2,
   parameter int unsigned STROBE_CYC   = 4,
   parameter int unsigned HOLD_CYC     = 1,
   parameter int unsigned RECOVERY_CYC = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              read,
   input  logic              write,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic              waitrequest,
   output logic [1:0]        otg_addr,
   output logic              otg_cs_n,
   output logic              otg_rd_n,
   output logic              otg_wr_n,
   output logic [DATA_W-1:0] otg_data_out,
   output logic              otg_data_oe,
   input  logic [DATA_W-1:0] otg_data_in,
`ifdef OTG_HPI_INT_SYNC_EN
   input  logic              otg_int,
   output logic              irq,
`endif
   output logic              busy
);

   localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] RECOVER_LD = (RECOVERY_CYC == 0) ? '0 : CNT_W'(RECOVERY_CYC - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             dir_wr, dir_nx;
   logic [1:0]       addr_q, addr_nx;
   logic             accept;
   logic             act_nx;

   // Next-state, counter reload and request capture decisions.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (read || write) begin
               accept   = 1'b1;
               state_nx = SETUP;
               cnt_nx   = SETUP_LD;
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               state_nx = STROBE;
               cnt_nx   = STROBE_LD;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         STROBE: begin
            if (cnt == '0) begin
               state_nx = HOLD;
               cnt_nx   = HOLD_LD;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               state_nx = (RECOVERY_CYC == 0) ? IDLE : RECOVER;
               cnt_nx   = RECOVER_LD;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         RECOVER: begin
            if (cnt == '0) begin
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
      // write wins when both requests are present; the read is dropped
      dir_nx  = accept ? write : dir_wr;
      addr_nx = accept ? address : addr_q;
      act_nx  = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
   end

   // State, counter and captured request registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         dir_wr <= 1'b0;
         addr_q <= HPI_DATA;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         dir_wr <= dir_nx;
         addr_q <= addr_nx;
      end
   end

   // Pin and Avalon outputs registered from the next state so every pin is a flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         otg_cs_n     <= 1'b1;
         otg_rd_n     <= 1'b1;
         otg_wr_n     <= 1'b1;
         otg_data_oe  <= 1'b0;
         otg_addr     <= HPI_DATA;
         otg_data_out <= '0;
         readdata     <= '0;
         waitrequest  <= 1'b1;
         busy         <= 1'b0;
      end else begin
         otg_cs_n    <= !act_nx;
         otg_addr    <= act_nx ? addr_nx : HPI_DATA;
         otg_data_oe <= act_nx && dir_nx;
         otg_rd_n    <= !((state_nx == STROBE) && !dir_nx);
         otg_wr_n    <= !((state_nx == STROBE) && dir_nx);
         waitrequest <= !((state_nx == HOLD) && (cnt_nx == '0));
         busy        <= (state_nx != IDLE);
         if (accept && write) begin
            otg_data_out <= writedata;
         end
         // sample the pad on the edge that ends the read strobe
         if ((state == STROBE) && (cnt == '0) && !dir_wr) begin
            readdata <= otg_data_in;
         end
      end
   end

`ifdef OTG_HPI_INT_SYNC_EN
   otg_hpi_access_ctrl_sync2 u_int_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (otg_int),
      .q       (irq)
   );
`endif

endmodule

// File: tb/tb_otg_hpi_access_ctrl.sv
// Bench for otg_hpi_access_ctrl: vector table of Avalon accesses with a
// scoreboard queue checked at each completion, plus hand-written reset and
// interrupt sequences.
module tb_otg_hpi_access_ctrl;
   import otg_hpi_pkg::*;

   localparam int SETUP_CYC    = 2;
   localparam int STROBE_CYC   = 4;
   localparam int HOLD_CYC     = 1;
   localparam int RECOVERY_CYC = 3;
   localparam int ACC_LAT      = SETUP_CYC + STROBE_CYC + HOLD_CYC + 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [15:0] writedata = '0;
   logic [15:0] readdata;
   logic        waitrequest;
   logic [1:0]  otg_addr;
   logic        otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe, busy;
   logic [15:0] otg_data_out, otg_data_in;
   logic [15:0] cur_din = '0;
`ifdef OTG_HPI_INT_SYNC_EN
   logic        otg_int = 1'b0;
   logic        irq;
`endif

   otg_hpi_access_ctrl #(
      .SETUP_CYC    (SETUP_CYC),
      .STROBE_CYC   (STROBE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .RECOVERY_CYC (RECOVERY_CYC)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .address      (address),
      .read         (read),
      .write        (write),
      .writedata    (writedata),
      .readdata     (readdata),
      .waitrequest  (waitrequest),
      .otg_addr     (otg_addr),
      .otg_cs_n     (otg_cs_n),
      .otg_rd_n     (otg_rd_n),
      .otg_wr_n     (otg_wr_n),
      .otg_data_out (otg_data_out),
      .otg_data_oe  (otg_data_oe),
      .otg_data_in  (otg_data_in),
`ifdef OTG_HPI_INT_SYNC_EN
      .otg_int      (otg_int),
      .irq          (irq),
`endif
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // HPI chip model: drives the pad only while the read strobe is low
   always_comb otg_data_in = otg_rd_n ? 16'h0000 : cur_din;

   typedef struct {
      logic        is_wr;
      logic [1:0]  addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          start;
      int          exp_lat;
      logic        b2b;
   } exp_t;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [1:0]  addr;
      logic [15:0] wdata;
      logic [15:0] din;
      logic [15:0] exp_rd;
   } vec_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   cs_cnt = 0, wr_cnt = 0, rd_cnt = 0, bad = 0, gap = 0, stray = 0;
   logic prev_cs = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Pin monitor and scoreboard consumer.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         prev_cs = 1'b1;
         gap     = 0;
      end else begin
         if (!otg_cs_n) begin
            if (prev_cs) begin
               if (sbq.size() > 0 && sbq[0].b2b) chk("cs_gap", gap, RECOVERY_CYC + 1);
               cs_cnt = 0; wr_cnt = 0; rd_cnt = 0; bad = 0;
            end
            cs_cnt++;
            if (!otg_wr_n) wr_cnt++;
            if (!otg_rd_n) rd_cnt++;
            if (sbq.size() > 0) begin
               if (otg_addr !== sbq[0].addr || otg_data_oe !== sbq[0].is_wr ||
                   (sbq[0].is_wr && otg_data_out !== sbq[0].wdata)) bad++;
            end
         end else begin
            gap = prev_cs ? gap + 1 : 1;
            if (!otg_rd_n || !otg_wr_n || otg_data_oe) stray++;
         end
         if (!waitrequest) begin
            if (sbq.size() == 0) begin
               chk("unexpected_completion", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("readdata", readdata, e.rdata);
               chk("cs_low_cycles", cs_cnt, SETUP_CYC + STROBE_CYC + HOLD_CYC);
               chk("wr_low_cycles", wr_cnt, e.is_wr ? STROBE_CYC : 0);
               chk("rd_low_cycles", rd_cnt, e.is_wr ? 0 : STROBE_CYC);
               chk("pins_during_cs", bad, 0);
               chk("latency", cyc - e.start + 1, e.exp_lat);
            end
         end
         prev_cs = otg_cs_n;
      end
   end

   // Present one request (caller is #1 after a posedge) and hold it until completion.
   task automatic req(input logic wr, input logic rd, input logic [1:0] a,
                      input logic [15:0] wd, input logic [15:0] din,
                      input logic [15:0] exp_rd, input logic b2b);
      exp_t e;
      logic done;
      read = rd; write = wr; address = a; writedata = wd; cur_din = din;
      e.is_wr = wr; e.addr = a; e.wdata = wd; e.rdata = exp_rd;
      e.start = cyc; e.b2b = b2b;
      e.exp_lat = b2b ? ACC_LAT + RECOVERY_CYC : ACC_LAT;
      sbq.push_back(e);
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (!waitrequest) done = 1'b1;
      end
      if (!done) begin
         chk("completion_timeout", 0, 1);
         sbq.delete();
      end
      @(posedge clk); #1;
      read = 1'b0; write = 1'b0;
   endtask

   vec_t vecs[6];

   initial begin
      logic seen;
      vecs[0] = '{1'b1, 1'b0, HPI_ADDRESS, 16'h1234, 16'h0000, 16'h0000};
      vecs[1] = '{1'b0, 1'b1, HPI_DATA,    16'h0000, 16'hBEEF, 16'hBEEF};
      vecs[2] = '{1'b0, 1'b1, HPI_STATUS,  16'h0000, 16'h5A5A, 16'h5A5A};
      vecs[3] = '{1'b1, 1'b1, HPI_MAILBOX, 16'hA5C3, 16'h1111, 16'h5A5A};
      vecs[4] = '{1'b1, 1'b0, HPI_DATA,    16'hFFFF, 16'h0000, 16'h5A5A};
      vecs[5] = '{1'b0, 1'b1, HPI_MAILBOX, 16'h0000, 16'h0001, 16'h0001};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_cs_n", otg_cs_n, 1);
      chk("rst_rd_n", otg_rd_n, 1);
      chk("rst_wr_n", otg_wr_n, 1);
      chk("rst_oe", otg_data_oe, 0);
      chk("rst_waitrequest", waitrequest, 1);
      chk("rst_busy", busy, 0);
      chk("rst_readdata", readdata, 0);
      chk("rst_addr", otg_addr, 0);
      chk("rst_data_out", otg_data_out, 0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      chk("idle_waitrequest", waitrequest, 1);
      chk("idle_busy", busy, 0);

      // table of accesses, back-to-back after the first
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].din,
             vecs[i].exp_rd, (i != 0));
      end

      // isolated write after an idle gap
      repeat (5) @(posedge clk); #1;
      req(1'b1, 1'b0, HPI_STATUS, 16'h0F0F, 16'h0000, 16'h0001, 1'b0);

      // asynchronous reset in the middle of the write strobe
      @(posedge clk); #1;
      write = 1'b1; address = HPI_MAILBOX; writedata = 16'hC0DE;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (!otg_wr_n) seen = 1'b1;
      end
      chk("midrst_reached_strobe", seen, 1);
      @(negedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_wr_n", otg_wr_n, 1);
      chk("midrst_rd_n", otg_rd_n, 1);
      chk("midrst_cs_n", otg_cs_n, 1);
      chk("midrst_oe", otg_data_oe, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_waitrequest", waitrequest, 1);
      write = 1'b0;
      @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      chk("postrst_readdata", readdata, 0);
      chk("postrst_busy", busy, 0);

      // normal read after the abandoned access
      @(posedge clk); #1;
      req(1'b0, 1'b1, HPI_STATUS, 16'h0000, 16'h7E81, 16'h7E81, 1'b0);

`ifdef OTG_HPI_INT_SYNC_EN
      // 3-clock interrupt pulse appears on irq 2 clocks later
      begin
         logic [6:0] irq_seen;
         logic [6:0] irq_exp;
         irq_exp = 7'b0011100;
         @(posedge clk); #1;
         for (int i = 0; i < 7; i++) begin
            otg_int = (i < 3);
            @(negedge clk);
            irq_seen[6-i] = irq;
            @(posedge clk); #1;
         end
         otg_int = 1'b0;
         chk("irq_pulse", irq_seen, irq_exp);
      end
`endif

      repeat (3) @(posedge clk);
      chk("stray_strobe_or_oe", stray, 0);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
